fht_loader: RTL and testbench
=============================

# fht_loader

Input-side loader for the FHT core: accepts a stream of raw ADC samples over a valid/ready handshake and distributes one N-point frame across the four RAM(A) banks of `fht_top` through its load port (`iDATA`, `iADDR_WR`, `iWE_0..3`). After the last write it issues the `iSTART` strobe, then back-pressures the stream until the transform completes and the downstream reader releases RAM(A). Sits directly upstream of `fht_top`.

## Interface
- `D_BIT`, default 17: extended data width used inside the FHT; the sample width is `D_BIT-1`.
- `A_BIT`, default 8: per-bank address width. Frame length is N = 4·2^A_BIT.
- `iCLK`, input, 1: clock. Single clock domain.
- `iRESET`, input, 1: reset. **Asynchronous, active-low.**
- `iVALID`, input, 1: sample on `iDATA` is valid.
- `iDATA`, input, D_BIT-1: raw ADC sample, not extended.
- `oREADY`, output, 1: the block accepts a sample this cycle.
- `oDATA`, output, D_BIT-1: sample to `fht_top.iDATA`.
- `oADDR_WR`, output, A_BIT: bank address to `fht_top.iADDR_WR`.
- `oWE_0`..`oWE_3`, output, 1 each: bank write enables to `fht_top.iWE_0..3`. At most one is high in any cycle.
- `oSTART`, output, 1: one-cycle strobe to `fht_top.iSTART`.
- `iRDY`, input, 1: from `fht_top.oRDY`.
- `iRELEASE`, input, 1: one-cycle pulse from the result reader; RAM(A) is free again.
- `oBUSY`, output, 1: a frame is loaded and not yet released.
- `oFRAME_CNT`, output, 8: count of frames started; wraps 255 → 0.

## Operation
- **FSM states:** LOAD, FIRE, RUN, HOLD. Reset state is LOAD.
- **LOAD:** `oREADY=1`.
  - Each handshake (`iVALID & oREADY`) takes the sample index n from a counter `cnt` of A_BIT+2 bits.
  - The write index is r = bitrev(n) over A_BIT+2 bits.
  - Bank = r[A_BIT+1:A_BIT]; address = r[A_BIT-1:0].
  - `cnt` increments on every handshake.
  - On the handshake with n = N-1, `cnt` wraps to 0 and the FSM goes to FIRE.
- **FIRE:** `oREADY=0`. Pulse `oSTART` for one cycle. Capture `iRDY` into `rdy_q`. Increment `oFRAME_CNT`. Go to RUN.
- **RUN:** `oREADY=0`. Wait for an `iRDY` rising edge (`iRDY & ~rdy_q`, with `rdy_q` updated every cycle). A level-high `iRDY` already present in FIRE is not a completion. On the edge, go to HOLD.
- **HOLD:** `oREADY=0`. Wait for `iRELEASE`, then go to LOAD.
- **`oBUSY`** is 1 in FIRE, RUN and HOLD.
- **`iRELEASE` outside HOLD** is ignored.
- **An `iRDY` edge and `iRELEASE` in the same RUN cycle:** go to HOLD. The release is not remembered.
- **`iVALID` low in LOAD:** no write, `cnt` holds, and the gap may be any length.
- **Reset mid-frame:** the partial frame is discarded; `cnt=0`, state LOAD.

## Timing
- **Reset values:** `oREADY=0` while `iRESET` is low, 1 from the first clock edge after release. All other outputs are 0.
- **Write latency:** a handshake at edge t drives `oDATA`, `oADDR_WR` and one `oWE_k` on the cycle after t, for exactly one cycle. All write outputs are registered.
- **Start latency:** the last handshake at edge t gives its write on t+1 and `oSTART` high on t+2. RAM(A) holds the full frame before the start strobe.
- **Throughput:** back-to-back handshakes give one write per cycle; a frame loads in N cycles.
- **Data:** no arithmetic. `oDATA` equals `iDATA` as registered; `fht_top` performs the sign extension.

## Configuration
- **Macro `FHT_LOADER_BITREV_EN`.**
- **Defined:** write index r = bitrev(n), as above.
- **Undefined:** natural order, r = n. In this case the bitrev instance is not compiled and the software or upstream source is responsible for reordering.

## Structure
- **`fht_defines.v`:** `D_BIT`, `A_BIT`, N and the FSM state encodings are defined here, next to the existing FHT defines.
- **Sub-module `fht_bitrev`:** parametric width, purely combinational index reversal, instantiated once. It is reusable by the result reader.

## Test plan
Bench configuration: A_BIT=2 (N=16), `FHT_LOADER_BITREV_EN` defined, unless stated otherwise.
- **Mapping:** stream samples 0..15 with `iVALID` held high. n=1 → `oWE_2`, addr 0; n=3 → `oWE_3`, addr 0; n=5 → `oWE_2`, addr 2. `oSTART` is high exactly 2 cycles after the 16th handshake.
- **Macro undefined:** n=5 → `oWE_1`, addr 1; n=14 → `oWE_3`, addr 2.
- **Gaps:** toggle `iVALID` randomly. There are still exactly 16 writes with no duplicates, each bank/address is written once, and `oREADY=0` from FIRE until `iRELEASE`.
- **RDY edge:** hold `iRDY=1` through FIRE and RUN → stays in RUN. Drive `iRDY` 0 then 1 → HOLD. `iRELEASE` → LOAD; `oFRAME_CNT` reads 1.
- **Reset mid-frame:** pull `iRESET` low after 7 handshakes → all outputs 0. A new frame's first sample (n=0) → `oWE_0`, addr 0.
- **Stray release:** an `iRELEASE` pulse in LOAD or RUN → no state change.

Source files
------------

// File: rtl/fht_loader_pkg.sv
// Shared types and defaults for the FHT input loader (fht_loader).
package fht_loader_pkg;

  localparam int D_BIT_DEF = 17;
  localparam int A_BIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Frame length: four RAM(A) banks of 2^a_bit words each.
  function automatic int frame_len(input int a_bit);
    return 4 << a_bit;
  endfunction

endpackage

// File: rtl/fht_loader_bitrev.sv
// fht_bitrev: purely combinational bit reversal of a W-bit index.
module fht_bitrev #(
  parameter int W = 10
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  for (genvar i = 0; i < W; i++) begin : g_rev
    assign rev[i] = idx[W-1-i];
  end

endmodule

// File: rtl/fht_loader.sv
// Streams one N-point frame into the four RAM(A) banks of fht_top, then starts it.
// Define FHT_LOADER_BITREV_EN for bit-reversed write order; otherwise natural order.
module fht_loader
  import fht_loader_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int A_BIT = A_BIT_DEF
) (
  input  logic               iCLK,
  input  logic               iRESET,
  // Handshake: a sample transfers on every rising iCLK where iVALID & oREADY.
  input  logic               iVALID,
  input  logic [D_BIT-2:0]   iDATA,
  output logic               oREADY,
  output logic [D_BIT-2:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic               oWE_0,
  output logic               oWE_1,
  output logic               oWE_2,
  output logic               oWE_3,
  output logic               oSTART,
  input  logic               iRDY,
  input  logic               iRELEASE,
  output logic               oBUSY,
  output logic [7:0]         oFRAME_CNT,
  output logic [1:0]         oSTATE
);

  localparam int CNT_W = A_BIT + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(frame_len(A_BIT) - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   widx;
  logic               ready_en;
  logic               rdy_q;
  logic               hs;
  logic               start_q;
  logic [3:0]         we_q;
  logic [D_BIT-2:0]   data_q;
  logic [A_BIT-1:0]   addr_q;
  logic [7:0]         frame_cnt;

`ifdef FHT_LOADER_BITREV_EN
  fht_bitrev #(.W(CNT_W)) u_bitrev (
    .idx (cnt),
    .rev (widx)
  );
`else
  assign widx = cnt;
`endif

  // ready_en keeps oREADY low while reset is asserted and until the first edge after it.
  assign oREADY = ready_en & (state == ST_LOAD);
  assign hs     = iVALID & oREADY;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (hs && (cnt == CNT_LAST)) state_nxt = ST_FIRE;
      ST_FIRE: state_nxt = ST_RUN;
      // Only a fresh rising edge of iRDY marks completion; a level carried over from FIRE does not.
      ST_RUN:  if (iRDY && !rdy_q) state_nxt = ST_HOLD;
      ST_HOLD: if (iRELEASE) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state <= ST_LOAD;
    else         state <= state_nxt;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      ready_en  <= 1'b0;
      rdy_q     <= 1'b0;
      cnt       <= '0;
      start_q   <= 1'b0;
      we_q      <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      frame_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      rdy_q    <= iRDY;
      start_q  <= (state == ST_FIRE);
      we_q     <= '0;
      if (state == ST_FIRE) frame_cnt <= frame_cnt + 8'd1;
      if (hs) begin
        cnt    <= cnt + CNT_W'(1);
        data_q <= iDATA;
        addr_q <= widx[A_BIT-1:0];
        we_q   <= 4'b0001 << widx[CNT_W-1:A_BIT];
      end
    end
  end

  assign oDATA      = data_q;
  assign oADDR_WR   = addr_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oSTART     = start_q;
  assign oBUSY      = (state != ST_LOAD);
  assign oFRAME_CNT = frame_cnt;
  assign oSTATE     = state;

endmodule

// File: tb/tb_fht_loader.sv
// Self-checking bench for fht_loader with A_BIT=2 (N=16) and D_BIT=17.
module tb_fht_loader;
  import fht_loader_pkg::*;

  localparam int D_BIT = 17;
  localparam int A_BIT = 2;
  localparam int N     = 16;
  localparam int SW    = D_BIT - 1;

  logic           iCLK = 1'b0;
  logic           iRESET = 1'b0;
  logic           iVALID = 1'b0;
  logic [SW-1:0]  iDATA = '0;
  logic           iRDY = 1'b0;
  logic           iRELEASE = 1'b0;
  logic           oREADY, oSTART, oBUSY;
  logic [SW-1:0]  oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic           oWE_0, oWE_1, oWE_2, oWE_3;
  logic [7:0]     oFRAME_CNT;
  logic [1:0]     oSTATE;
  logic [3:0]     wr_bus;

  fht_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iDATA(iDATA), .oREADY(oREADY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2),
    .oWE_3(oWE_3), .oSTART(oSTART), .iRDY(iRDY), .iRELEASE(iRELEASE), .oBUSY(oBUSY),
    .oFRAME_CNT(oFRAME_CNT), .oSTATE(oSTATE)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;
  assign wr_bus = {oWE_3, oWE_2, oWE_1, oWE_0};

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector table: hand-computed bank one-hot / address for both write orders.
  typedef struct {
    logic [SW-1:0] data;
    logic [3:0]    we_rev;
    logic [1:0]    addr_rev;
    logic [3:0]    we_nat;
    logic [1:0]    addr_nat;
  } vec_t;

  vec_t vecs[N];

  task automatic set_vec(input int i, input logic [SW-1:0] d, input logic [3:0] wr,
                         input logic [1:0] ar, input logic [3:0] wn, input logic [1:0] an);
    vecs[i].data = d; vecs[i].we_rev = wr; vecs[i].addr_rev = ar;
    vecs[i].we_nat = wn; vecs[i].addr_nat = an;
  endtask

  function automatic logic [3:0] exp_we(input int i);
`ifdef FHT_LOADER_BITREV_EN
    return vecs[i].we_rev;
`else
    return vecs[i].we_nat;
`endif
  endfunction

  function automatic logic [1:0] exp_addr(input int i);
`ifdef FHT_LOADER_BITREV_EN
    return vecs[i].addr_rev;
`else
    return vecs[i].addr_nat;
`endif
  endfunction

  // scoreboard for the gapped frame
  logic [SW+5:0] exp_q[$];
  logic          mon_en = 1'b0;
  int            wr_cnt = 0;
  bit            seen[4][4];

  always @(negedge iCLK) begin
    if (mon_en && (wr_bus != 4'b0)) begin
      int bank;
      logic [SW+5:0] e;
      bank = 0;
      wr_cnt++;
      for (int k = 0; k < 4; k++) if (wr_bus[k]) bank = k;
      check("gap_onehot", 32'($onehot(wr_bus)), 32'd1);
      check("gap_dup", 32'(seen[bank][oADDR_WR]), 32'd0);
      seen[bank][oADDR_WR] = 1'b1;
      if (exp_q.size() == 0) begin
        check("gap_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("gap_write", 32'({oDATA, wr_bus, oADDR_WR}), 32'(e));
      end
    end
  end

  initial begin
    int hs;
    int cyc;
    set_vec(0,  16'h5A00, 4'b0001, 2'd0, 4'b0001, 2'd0);
    set_vec(1,  16'h5A17, 4'b0100, 2'd0, 4'b0001, 2'd1);
    set_vec(2,  16'hC3A2, 4'b0010, 2'd0, 4'b0001, 2'd2);
    set_vec(3,  16'h0F0F, 4'b1000, 2'd0, 4'b0001, 2'd3);
    set_vec(4,  16'hFFFF, 4'b0001, 2'd2, 4'b0010, 2'd0);
    set_vec(5,  16'h8001, 4'b0100, 2'd2, 4'b0010, 2'd1);
    set_vec(6,  16'h1234, 4'b0010, 2'd2, 4'b0010, 2'd2);
    set_vec(7,  16'hABCD, 4'b1000, 2'd2, 4'b0010, 2'd3);
    set_vec(8,  16'h7FFF, 4'b0001, 2'd1, 4'b0100, 2'd0);
    set_vec(9,  16'h8000, 4'b0100, 2'd1, 4'b0100, 2'd1);
    set_vec(10, 16'h0001, 4'b0010, 2'd1, 4'b0100, 2'd2);
    set_vec(11, 16'h2468, 4'b1000, 2'd1, 4'b0100, 2'd3);
    set_vec(12, 16'h1357, 4'b0001, 2'd3, 4'b1000, 2'd0);
    set_vec(13, 16'hDEAD, 4'b0100, 2'd3, 4'b1000, 2'd1);
    set_vec(14, 16'hBEEF, 4'b0010, 2'd3, 4'b1000, 2'd2);
    set_vec(15, 16'h55AA, 4'b1000, 2'd3, 4'b1000, 2'd3);

    // reset values
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_ready", 32'(oREADY), 32'd0);
    check("rst_we", 32'(wr_bus), 32'd0);
    check("rst_start", 32'(oSTART), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_frame_cnt", 32'(oFRAME_CNT), 32'd0);
    check("rst_data", 32'(oDATA), 32'd0);
    check("rst_addr", 32'(oADDR_WR), 32'd0);
    check("rst_state", 32'(oSTATE), 32'(ST_LOAD));
    iRESET = 1'b1;
    @(negedge iCLK);
    check("ready_after_rst", 32'(oREADY), 32'd1);

    // back-to-back frame from the table, iRDY held high across FIRE/RUN
    iRDY = 1'b1;
    iVALID = 1'b1;
    iDATA = vecs[0].data;
    for (int i = 0; i < N; i++) begin
      @(posedge iCLK);
      #1;
      if (i < N - 1) iDATA = vecs[i + 1].data;
      else iVALID = 1'b0;
      @(negedge iCLK);
      check($sformatf("map_we_n%0d", i), 32'(wr_bus), 32'(exp_we(i)));
      check($sformatf("map_addr_n%0d", i), 32'(oADDR_WR), 32'(exp_addr(i)));
      check($sformatf("map_data_n%0d", i), 32'(oDATA), 32'(vecs[i].data));
      check($sformatf("map_start_low_n%0d", i), 32'(oSTART), 32'd0);
    end
    check("fire_state", 32'(oSTATE), 32'(ST_FIRE));
    check("fire_ready", 32'(oREADY), 32'd0);
    @(negedge iCLK);
    check("start_pulse", 32'(oSTART), 32'd1);
    check("start_no_write", 32'(wr_bus), 32'd0);
    check("frame_cnt_1", 32'(oFRAME_CNT), 32'd1);
    check("run_state", 32'(oSTATE), 32'(ST_RUN));
    @(negedge iCLK);
    check("start_one_cycle", 32'(oSTART), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      check("rdy_level_stays_run", 32'(oSTATE), 32'(ST_RUN));
    end
    iRELEASE = 1'b1;
    @(negedge iCLK);
    iRELEASE = 1'b0;
    check("stray_release_run", 32'(oSTATE), 32'(ST_RUN));
    iRDY = 1'b0;
    @(negedge iCLK);
    check("rdy_low_run", 32'(oSTATE), 32'(ST_RUN));
    iRDY = 1'b1;
    @(negedge iCLK);
    check("rdy_edge_hold", 32'(oSTATE), 32'(ST_HOLD));
    check("hold_ready", 32'(oREADY), 32'd0);
    check("hold_busy", 32'(oBUSY), 32'd1);
    iRELEASE = 1'b1;
    @(negedge iCLK);
    iRELEASE = 1'b0;
    check("release_load", 32'(oSTATE), 32'(ST_LOAD));
    check("release_ready", 32'(oREADY), 32'd1);
    check("release_busy", 32'(oBUSY), 32'd0);
    check("release_frame_cnt", 32'(oFRAME_CNT), 32'd1);

    // stray release while loading
    iRELEASE = 1'b1;
    @(negedge iCLK);
    iRELEASE = 1'b0;
    check("stray_release_load", 32'(oSTATE), 32'(ST_LOAD));
    check("stray_release_no_write", 32'(wr_bus), 32'd0);

    // frame with random iVALID gaps
    iRDY = 1'b0;
    wr_cnt = 0;
    mon_en = 1'b1;
    hs = 0;
    cyc = 0;
    while (hs < N && cyc < 400) begin
      iVALID = 1'($urandom_range(0, 1));
      iDATA = SW'($urandom);
      if (iVALID && oREADY) begin
        exp_q.push_back({iDATA, exp_we(hs), exp_addr(hs)});
        hs++;
      end
      @(negedge iCLK);
      cyc++;
    end
    iVALID = 1'b0;
    check("gap_handshakes", 32'(hs), 32'(N));
    iVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      check("gap_ready_low_busy", 32'(oREADY), 32'd0);
    end
    iVALID = 1'b0;
    iRDY = 1'b1;
    @(negedge iCLK);
    check("gap_hold", 32'(oSTATE), 32'(ST_HOLD));
    check("gap_hold_ready", 32'(oREADY), 32'd0);
    iRELEASE = 1'b1;
    @(negedge iCLK);
    iRELEASE = 1'b0;
    iRDY = 1'b0;
    check("gap_release_load", 32'(oSTATE), 32'(ST_LOAD));
    mon_en = 1'b0;
    check("gap_write_count", 32'(wr_cnt), 32'(N));
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 4; a++)
        check($sformatf("gap_cover_b%0d_a%0d", b, a), 32'(seen[b][a]), 32'd1);
    check("frame_cnt_2", 32'(oFRAME_CNT), 32'd2);

    // reset in the middle of a frame
    iVALID = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iDATA = vecs[i].data;
      @(negedge iCLK);
    end
    iVALID = 1'b0;
    iRESET = 1'b0;
    #1;
    check("midrst_ready", 32'(oREADY), 32'd0);
    check("midrst_we", 32'(wr_bus), 32'd0);
    check("midrst_data", 32'(oDATA), 32'd0);
    check("midrst_addr", 32'(oADDR_WR), 32'd0);
    check("midrst_frame_cnt", 32'(oFRAME_CNT), 32'd0);
    check("midrst_busy", 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    iRESET = 1'b1;
    @(negedge iCLK);
    iVALID = 1'b1;
    iDATA = 16'hBEEF;
    @(negedge iCLK);
    iVALID = 1'b0;
    check("midrst_n0_we", 32'(wr_bus), 32'h1);
    check("midrst_n0_addr", 32'(oADDR_WR), 32'd0);
    check("midrst_n0_data", 32'(oDATA), 32'hBEEF);
    iVALID = 1'b1;
    iDATA = vecs[1].data;
    @(negedge iCLK);
    iVALID = 1'b0;
    check("midrst_n1_we", 32'(wr_bus), 32'(exp_we(1)));
    check("midrst_n1_addr", 32'(oADDR_WR), 32'(exp_addr(1)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
